// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between CPU MEM stage and debug port
// The CPU owns the memory; debug gets idle cycles or a one-cycle forced slot after starvation.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              cpu_pri;
  logic              cpu_act;
  logic              idle_grant;
  logic              force_grant;

  // rst_n gates the grant terms so nothing reaches memory while reset is held
  assign cpu_act     = cpu_mem_read | cpu_mem_write;
  assign idle_grant  = rst_n & dbg_req & ~cpu_act;
  assign force_grant = rst_n & dbg_req & cpu_act & ~cpu_pri & (wait_cnt == WAIT_MAX);
  assign dbg_gnt     = idle_grant | force_grant;
  assign cpu_stall   = force_grant;
  assign cpu_rdata   = mem_rdata;

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_read  = cpu_mem_read & rst_n;
    mem_write = cpu_mem_write & rst_n;
    if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_read  = ~dbg_we;
      mem_write = dbg_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      cpu_pri      <= 1'b0;
      dbg_rvalid   <= 1'b0;
      dbg_rdata    <= '0;
      conflict_cnt <= '0;
    end else begin
      if (dbg_gnt || !dbg_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      // one guaranteed CPU cycle after every forced grant
      cpu_pri    <= force_grant;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
      if (force_grant && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule
